// File: rtl/hazard_pkg.sv
// Shared constants, timer opcodes and counter-width helper for the load-use hazard scoreboard.
// Optional stall-cycle performance counter in the top is enabled by defining HAZARD_PERF_EN.
package hazard_pkg;

   localparam int unsigned REG_ADDR_DEF = 5;
   localparam int unsigned LOAD_LAT_MAX = 7;

   typedef enum logic [1:0] {
      TMR_HOLD  = 2'd0,
      TMR_DEC   = 2'd1,
      TMR_LOAD  = 2'd2,
      TMR_CLEAR = 2'd3
   } tmr_op_e;

   // Bits needed to hold a countdown from lat down to 0; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned lat);
      int unsigned w;
      w = $clog2(lat + 1);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int unsigned CNT_W_MAX = cnt_width(LOAD_LAT_MAX);

endpackage

// File: rtl/hazard_reg_timer.sv
// Per-register load countdown timer: clear/hold/reload/decrement, pending while nonzero.
// Decrement stops at zero so the timer can never wrap.
module hazard_reg_timer
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CW       = cnt_width(LOAD_LAT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  tmr_op_e       op_i,
   output logic [CW-1:0] cnt_o,
   output logic          pending_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      unique case (op_i)
         TMR_CLEAR: cnt_d = '0;
         TMR_HOLD:  cnt_d = cnt_q;
         TMR_LOAD:  cnt_d = CW'(LOAD_LAT);
         TMR_DEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default:   cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign pending_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: per-register load timers, ID-stage stall with store-data exemption.
// Define HAZARD_PERF_EN to build the saturating stall_cycles counter; otherwise it is tied to zero.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR = REG_ADDR_DEF,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [REG_ADDR-1:0] id_src1,
   input  logic [REG_ADDR-1:0] id_src2,
   input  logic [REG_ADDR-1:0] id_dst,
   input  logic                id_memread,
   input  logic                id_memwrite,
   input  logic                mem_busy,
   input  logic                flush,
   output logic                stall,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic [31:0]         stall_cycles
);

   localparam int unsigned CW = cnt_width(LOAD_LAT);

   // Register 0 has no timer; its count and pending bit are constant zero.
   logic [CW-1:0]       cnt  [1:NUM_REGS-1];
   logic [NUM_REGS-1:1] pend;

   logic [CW-1:0] src1_cnt;
   logic [CW-1:0] src2_cnt;
   logic          src1_pend;
   logic          src2_pend;
   logic          hit1;
   logic          hit2;
   logic          issue;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_tmr
      logic    ld_sel;
      tmr_op_e op;

      assign ld_sel = issue && id_memread && (id_dst == REG_ADDR'(r));

      always_comb begin
         if (flush) begin
            op = TMR_CLEAR;
         end else if (mem_busy) begin
            op = TMR_HOLD;
         end else if (ld_sel) begin
            op = TMR_LOAD;
         end else begin
            op = TMR_DEC;
         end
      end

      hazard_reg_timer #(
         .LOAD_LAT (LOAD_LAT),
         .CW       (CW)
      ) u_tmr (
         .clk       (clk),
         .rst_n     (rst_n),
         .op_i      (op),
         .cnt_o     (cnt[r]),
         .pending_o (pend[r])
      );
   end

   // Source 0 and addresses at or beyond NUM_REGS never match any timer.
   always_comb begin
      src1_cnt  = '0;
      src2_cnt  = '0;
      src1_pend = 1'b0;
      src2_pend = 1'b0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (id_src1 == REG_ADDR'(i)) begin
            src1_cnt  = cnt[i];
            src1_pend = pend[i];
         end
         if (id_src2 == REG_ADDR'(i)) begin
            src2_cnt  = cnt[i];
            src2_pend = pend[i];
         end
      end
   end

   // Store data is forwarded at MEM, so a store's src2 clears one cycle early.
   assign hit1  = src1_pend;
   assign hit2  = src2_pend && !(id_memwrite && (src2_cnt == CW'(1)));
   assign stall = id_valid && (hit1 || hit2);
   assign issue = id_valid && !stall && !mem_busy && !flush;

   assign pending_mask = {pend, 1'b0};

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`else
   logic unused_src1_cnt;
   assign unused_src1_cnt = ^src1_cnt;
   assign stall_cycles    = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: two scoreboards (LOAD_LAT 1 and 3) on shared stimulus, timestamp reference model.
module tb_hazard_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_src1;
   logic [4:0]  id_src2;
   logic [4:0]  id_dst;
   logic        id_memread;
   logic        id_memwrite;
   logic        mem_busy;
   logic        flush;
   logic        stall_a, stall_b;
   logic [31:0] mask_a, mask_b;
   logic [31:0] sc_a, sc_b;

   int pass_cnt;
   int total_cnt;

   // Reference model: absolute cycle at which each register's load result becomes usable.
   int rdy [2][32];
   int lat [2];
   int perf [2];
   int now_c;

   hazard_scoreboard #(.REG_ADDR(5), .NUM_REGS(32), .LOAD_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_dst(id_dst), .id_memread(id_memread), .id_memwrite(id_memwrite), .mem_busy(mem_busy),
      .flush(flush), .stall(stall_a), .pending_mask(mask_a), .stall_cycles(sc_a)
   );

   hazard_scoreboard #(.REG_ADDR(5), .NUM_REGS(32), .LOAD_LAT(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_dst(id_dst), .id_memread(id_memread), .id_memwrite(id_memwrite), .mem_busy(mem_busy),
      .flush(flush), .stall(stall_b), .pending_mask(mask_b), .stall_cycles(sc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic get_stall(input int k);
      return (k == 0) ? stall_a : stall_b;
   endfunction

   function automatic logic [31:0] get_mask(input int k);
      return (k == 0) ? mask_a : mask_b;
   endfunction

   function automatic logic [31:0] get_sc(input int k);
      return (k == 0) ? sc_a : sc_b;
   endfunction

   function automatic bit m_pend(input int k, input int r);
      return (r != 0) && (rdy[k][r] > now_c);
   endfunction

   function automatic bit m_stall(input int k);
      int  s1;
      int  s2;
      bit  h1;
      bit  h2;
      s1 = int'(id_src1);
      s2 = int'(id_src2);
      h1 = m_pend(k, s1);
      h2 = m_pend(k, s2) && !(id_memwrite && (rdy[k][s2] - now_c == 1));
      return id_valid && (h1 || h2);
   endfunction

   function automatic logic [31:0] m_mask(input int k);
      logic [31:0] m;
      m = '0;
      for (int r = 0; r < 32; r++) m[r] = m_pend(k, r);
      return m;
   endfunction

   function automatic logic [31:0] m_sc(input int k);
`ifdef HAZARD_PERF_EN
      return perf[k];
`else
      return (k < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         perf[k] = 0;
         for (int r = 0; r < 32; r++) rdy[k][r] = 0;
      end
   endtask

   task automatic model_edge();
      bit st;
      bit iss;
      for (int k = 0; k < 2; k++) begin
         st  = m_stall(k);
         iss = id_valid && !st && !mem_busy && !flush;
         if (st) perf[k]++;
         if (flush) begin
            for (int r = 0; r < 32; r++) rdy[k][r] = 0;
         end else if (mem_busy) begin
            for (int r = 0; r < 32; r++) if (m_pend(k, r)) rdy[k][r]++;
         end else if (iss && id_memread && id_dst != 0) begin
            rdy[k][id_dst] = now_c + 1 + lat[k];
         end
      end
      now_c++;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input int s1, input int s2, input int d,
                        input logic mr, input logic mw, input logic busy, input logic fl);
      id_valid    = v;
      id_src1     = 5'(s1);
      id_src2     = 5'(s2);
      id_dst      = 5'(d);
      id_memread  = mr;
      id_memwrite = mw;
      mem_busy    = busy;
      flush       = fl;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b1, 3, 5, 7, 1'b1, 1'b0, 1'b0, 1'b0);
      model_clear();
      for (int k = 0; k < 2; k++) begin
         total_cnt++;
         if (get_stall(k) !== 1'b0) $display("FAIL reset_stall[%0d]: got %b expected 0", k, get_stall(k));
         else pass_cnt++;
         total_cnt++;
         if (get_mask(k) !== 32'h0) $display("FAIL reset_mask[%0d]: got %h expected 0", k, get_mask(k));
         else pass_cnt++;
         total_cnt++;
         if (get_sc(k) !== 32'h0) $display("FAIL reset_sc[%0d]: got %0d expected 0", k, get_sc(k));
         else pass_cnt++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_lat1_load_use();
      int n;
      do_reset();
      drive(1'b1, 0, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (stall_a !== 1'b0) $display("FAIL l1_load_nostall: got %b expected 0", stall_a);
      else pass_cnt++;
      tick();
      drive(1'b1, 3, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (mask_a !== 32'h0000_0008) $display("FAIL l1_mask_r3: got %h expected 00000008", mask_a);
      else pass_cnt++;
      n = 0;
      while (stall_a === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      total_cnt++;
      if (n !== 1) $display("FAIL l1_stall_len: got %0d expected 1", n);
      else pass_cnt++;
      total_cnt++;
      if (mask_a !== 32'h0) $display("FAIL l1_mask_after: got %h expected 0", mask_a);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_lat3_src_and_store();
      int n;
      do_reset();
      drive(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5, 0, 6, 1'b0, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (stall_b === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      total_cnt++;
      if (n !== 3) $display("FAIL l3_src1_stall_len: got %0d expected 3", n);
      else pass_cnt++;
      tick();
      drive(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (stall_b === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      total_cnt++;
      if (n !== 2) $display("FAIL l3_store_stall_len: got %0d expected 2", n);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_mem_busy_freeze();
      int n;
      do_reset();
      drive(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5, 0, 6, 1'b0, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (stall_b === 1'b1 && n < 30) begin
         n++;
         tick();
         drive(1'b1, 5, 0, 6, 1'b0, 1'b0, (n >= 1 && n <= 4), 1'b0);
         if (n == 3) begin
            total_cnt++;
            if (mask_b !== 32'h0000_0020) $display("FAIL busy_mask_frozen: got %h expected 00000020", mask_b);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (n !== 7) $display("FAIL busy_stall_len: got %0d expected 7", n);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_r0_never_pending();
      do_reset();
      drive(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         total_cnt++;
         if (get_stall(k) !== 1'b0) $display("FAIL r0_stall[%0d]: got %b expected 0", k, get_stall(k));
         else pass_cnt++;
         total_cnt++;
         if (get_mask(k) !== 32'h0) $display("FAIL r0_mask[%0d]: got %h expected 0", k, get_mask(k));
         else pass_cnt++;
      end
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 0, 0, 7, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 0, 0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         total_cnt++;
         if (get_mask(k) !== 32'h0) $display("FAIL flush_same_cycle[%0d]: got %h expected 0", k, get_mask(k));
         else pass_cnt++;
      end
      tick();
      drive(1'b1, 7, 0, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         total_cnt++;
         if (get_stall(k) !== 1'b1) $display("FAIL flush_pre_stall[%0d]: got %b expected 1", k, get_stall(k));
         else pass_cnt++;
      end
      tick();
      drive(1'b1, 7, 0, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         total_cnt++;
         if (get_stall(k) !== 1'b0) $display("FAIL flush_post_stall[%0d]: got %b expected 0", k, get_stall(k));
         else pass_cnt++;
         total_cnt++;
         if (get_mask(k) !== 32'h0) $display("FAIL flush_post_mask[%0d]: got %h expected 0", k, get_mask(k));
         else pass_cnt++;
      end
      tick();
   endtask

   task automatic test_random();
      int mr;
      int mw;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         mr = ($urandom_range(0, 9) < 3) ? 1 : 0;
         mw = (mr == 0 && $urandom_range(0, 9) < 2) ? 1 : 0;
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), mr[0], mw[0], $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 5);
         for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (get_stall(k) !== m_stall(k))
               $display("FAIL rand_stall[%0d] cyc %0d: got %b expected %b", k, c, get_stall(k), m_stall(k));
            else pass_cnt++;
            total_cnt++;
            if (get_mask(k) !== m_mask(k))
               $display("FAIL rand_mask[%0d] cyc %0d: got %h expected %h", k, c, get_mask(k), m_mask(k));
            else pass_cnt++;
            total_cnt++;
            if (get_sc(k) !== m_sc(k))
               $display("FAIL rand_sc[%0d] cyc %0d: got %0d expected %0d", k, c, get_sc(k), m_sc(k));
            else pass_cnt++;
         end
         tick();
      end
   endtask

   task automatic test_perf_and_async_reset();
      int n;
      logic [31:0] exp_sc;
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 0, 0, i, 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
         drive(1'b1, i, 0, 20, 1'b0, 1'b0, 1'b0, 1'b0);
         n = 0;
         while (stall_a === 1'b1 && n < 20) begin
            n++;
            tick();
         end
         tick();
      end
`ifdef HAZARD_PERF_EN
      exp_sc = 32'd10;
`else
      exp_sc = 32'd0;
`endif
      total_cnt++;
      if (sc_a !== exp_sc) $display("FAIL perf_10_pairs: got %0d expected %0d", sc_a, exp_sc);
      else pass_cnt++;
      drive(1'b1, 0, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 3, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (stall_a !== 1'b1) $display("FAIL arst_pre_stall: got %b expected 1", stall_a);
      else pass_cnt++;
      rst_n = 1'b0;
      model_clear();
      #1;
      for (int k = 0; k < 2; k++) begin
         total_cnt++;
         if (get_stall(k) !== 1'b0) $display("FAIL arst_stall[%0d]: got %b expected 0", k, get_stall(k));
         else pass_cnt++;
         total_cnt++;
         if (get_sc(k) !== 32'h0) $display("FAIL arst_sc[%0d]: got %0d expected 0", k, get_sc(k));
         else pass_cnt++;
         total_cnt++;
         if (get_mask(k) !== 32'h0) $display("FAIL arst_mask[%0d]: got %h expected 0", k, get_mask(k));
         else pass_cnt++;
      end
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      now_c     = 0;
      lat[0]    = 1;
      lat[1]    = 3;
      rst_n     = 1'b0;
      model_clear();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_lat1_load_use();
      test_lat3_src_and_store();
      test_mem_busy_freeze();
      test_r0_never_pending();
      test_flush();
      test_random();
      test_perf_and_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
